address_sequencer: RTL and testbench
====================================

ADDRESS_SEQUENCER -- requirements
Module: address_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, 32, address width in bits.
REQ-002 SHALL have parameter STEP_WIDTH, 8, step-size width in bits.
REQ-003 SHALL have a single clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on posedge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  latch configuration and begin a run.
REQ-007 stop  input  1  abort the run and go idle.
REQ-008 start_addr  input  WIDTH  lower bound, inclusive.
REQ-009 end_addr  input  WIDTH  upper bound, inclusive.
REQ-010 step  input  STEP_WIDTH  address increment; 0 is treated as 1.
REQ-011 mode  input  2  0=ONESHOT, 1=LOOP, 2=PINGPONG, 3=reserved (behaves as LOOP).
REQ-012 forward  input  1  initial direction: 1=up, 0=down.
REQ-013 addr_ready  input  1  consumer accepts the current address.
REQ-014 address  output  WIDTH  current address.
REQ-015 addr_valid  output  1  address is valid for consumption.
REQ-016 busy  output  1  high in RUN.
REQ-017 dir  output  1  current direction.
REQ-018 done  output  1  one-cycle pulse at ONESHOT completion.
REQ-019 wrapped  output  1  one-cycle pulse on each LOOP/PINGPONG boundary event.
REQ-020 cfg_err  output  1  one-cycle pulse when start is rejected.

Function
REQ-021 SHALL implement states IDLE and RUN; addr_valid=busy=(state==RUN).
REQ-022 start in IDLE with start_addr<=end_addr: the SHALL latch start_addr, end_addr, step, mode and forward; next cycle state=RUN, address=start_addr if forward, else end_addr, dir=forward.
REQ-023 start with start_addr>end_addr SHALL be rejected: cfg_err pulses next cycle, and state and address are unchanged.
REQ-024 start in RUN SHALL restart per REQ-022/023 and takes priority over any advance.
REQ-025 In RUN, addr_valid&&addr_ready SHALL advance: address moves by step in direction dir, visible next cycle; without addr_ready, address holds.
REQ-026 Boundary detection SHALL use WIDTH+1-bit arithmetic.
- Up: boundary when address+step>end.
- Down: boundary when address<start+step.
- Intermediate overflow never wraps through 0.
REQ-027 ONESHOT boundary on advance: the block SHALL go to IDLE, and done pulses next cycle. address holds its last value.
REQ-028 LOOP boundary on advance:
- Up: address SHALL become the latched start.
- Down: address SHALL become the latched end.
- wrapped pulses next cycle; dir is unchanged.
REQ-029 PINGPONG boundary on advance: dir SHALL flip, and address becomes address∓step in the new direction, clamped to [start,end]. wrapped pulses next cycle.
REQ-030 If start==end, every advance SHALL be a boundary event; address stays at start, and done/wrapped behave as above.
REQ-031 stop SHALL have priority over an advance: state goes to IDLE next cycle, with no address change and no done.
REQ-032 Priority SHALL be rst > start > stop > advance.
REQ-033 Configuration inputs SHALL be ignored except in the start cycle.

Reset
REQ-034 rst SHALL force state=IDLE, address=0, dir=1, and done=wrapped=cfg_err=0 at the next edge, including mid-run.
REQ-035 The latched configuration SHALL reset to start=0, end=0, step=1, mode=LOOP.

Structure
REQ-036 Package addr_seq_pkg SHALL hold the mode_t enum (MODE_ONESHOT, MODE_LOOP, MODE_PINGPONG) and the state_t enum (S_IDLE, S_RUN).
REQ-037 Combinational sub-module addr_step_calc SHALL compute the next address, the boundary flag and the next direction from address, dir, step, bounds and mode.

Verification
REQ-038 start=4, end=10, step=3, LOOP, forward=1, ready held high -> addresses 4,7,10,4,7; wrapped pulses once, after 10.
REQ-039 start=0, end=5, step=1, LOOP, forward=0 -> addresses 5,4,3,2,1,0,5; wrapped pulses after 0.
REQ-040 start=4, end=10, step=3, PINGPONG, forward=1 -> addresses 4,7,10,7,4,7; dir flips after 10 and again after 4.
REQ-041 start=0, end=3, ONESHOT, ready high -> addresses 0,1,2,3, then done pulses, busy=0, address=3; with ready toggling, each address holds until accepted.
REQ-042 WIDTH=8, start=250, end=255, step=4, LOOP -> addresses 250,254,250; the address never reaches 0-3.
REQ-043 stop and ready in the same cycle -> no advance, busy=0 next cycle. rst mid-run -> address=0, busy=0. start with start=9, end=3 -> cfg_err pulses and state stays IDLE.

Source files
------------

// File: rtl/address_sequencer_pkg.sv
// Shared types for the address sequencer: operating modes and control states.
package addr_seq_pkg;

  typedef enum logic [1:0] {
    MODE_ONESHOT  = 2'd0,
    MODE_LOOP     = 2'd1,
    MODE_PINGPONG = 2'd2
  } mode_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/address_sequencer_if.sv
// Address stream to the consumer. An address transfers on any clock edge
// where addr_valid && addr_ready; address is stable while valid is high and ready is low.
interface address_sequencer_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] address;
  logic             addr_valid;
  logic             addr_ready;

  modport master (output address, output addr_valid, input addr_ready);
  modport slave  (input address, input addr_valid, output addr_ready);
endinterface

// File: rtl/address_sequencer_step_calc.sv
// Next-address computation with boundary detection in WIDTH+1 bits so that
// stepping past the top of the address space never wraps through zero.
module addr_step_calc
  import addr_seq_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int STEP_WIDTH = 8
) (
  input  logic [WIDTH-1:0]      addr,
  input  logic                  dir,
  input  logic [STEP_WIDTH-1:0] step,
  input  logic [WIDTH-1:0]      lo,
  input  logic [WIDTH-1:0]      hi,
  input  logic [1:0]            mode,
  output logic [WIDTH-1:0]      next_addr,
  output logic                  boundary,
  output logic                  next_dir
);
  localparam int EW = WIDTH + 1;

  logic [EW-1:0]    sum;
  logic [EW-1:0]    lo_plus;
  logic [WIDTH-1:0] diff;
  logic             up_hit;
  logic             down_hit;

  assign sum      = {1'b0, addr} + EW'(step);
  assign lo_plus  = {1'b0, lo} + EW'(step);
  assign diff     = addr - WIDTH'(step);
  assign up_hit   = sum > {1'b0, hi};
  assign down_hit = {1'b0, addr} < lo_plus;

  always_comb begin
    next_addr = addr;
    next_dir  = dir;
    boundary  = (dir == DIR_UP) ? up_hit : down_hit;
    if (!boundary) begin
      next_addr = (dir == DIR_UP) ? sum[WIDTH-1:0] : diff;
    end else begin
      case (mode)
        MODE_ONESHOT: next_addr = addr;
        MODE_PINGPONG: begin
          // Reverse and take one step the other way, clamped to the window.
          next_dir = ~dir;
          if (dir == DIR_UP) next_addr = down_hit ? lo : diff;
          else               next_addr = up_hit ? hi : sum[WIDTH-1:0];
        end
        default: next_addr = (dir == DIR_UP) ? lo : hi;
      endcase
    end
  end
endmodule

// File: rtl/address_sequencer.sv
// Programmable address generator: walks [start,end] by step in one-shot,
// looping or ping-pong fashion, handing each address out over a valid/ready port.
module address_sequencer
  import addr_seq_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int STEP_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [WIDTH-1:0]      start_addr,
  input  logic [WIDTH-1:0]      end_addr,
  input  logic [STEP_WIDTH-1:0] step,
  input  logic [1:0]            mode,
  input  logic                  forward,
  address_sequencer_if.master   addr_bus,
  output logic                  busy,
  output logic                  dir,
  output logic                  done,
  output logic                  wrapped,
  output logic                  cfg_err,
  output state_t                state_dbg
);
  state_t                state_q, state_n;
  logic [WIDTH-1:0]      addr_q, addr_n;
  logic [WIDTH-1:0]      lo_q, lo_n, hi_q, hi_n;
  logic [STEP_WIDTH-1:0] step_q, step_n;
  logic [1:0]            mode_q, mode_n;
  logic                  dir_q, dir_n;
  logic                  done_n, wrapped_n, cfg_err_n;

  logic [WIDTH-1:0] calc_addr;
  logic             calc_boundary;
  logic             calc_dir;

  addr_step_calc #(.WIDTH(WIDTH), .STEP_WIDTH(STEP_WIDTH)) u_calc (
    .addr      (addr_q),
    .dir       (dir_q),
    .step      (step_q),
    .lo        (lo_q),
    .hi        (hi_q),
    .mode      (mode_q),
    .next_addr (calc_addr),
    .boundary  (calc_boundary),
    .next_dir  (calc_dir)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      dir_q   <= DIR_UP;
      lo_q    <= '0;
      hi_q    <= '0;
      step_q  <= STEP_WIDTH'(1);
      mode_q  <= MODE_LOOP;
      done    <= 1'b0;
      wrapped <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      state_q <= state_n;
      addr_q  <= addr_n;
      dir_q   <= dir_n;
      lo_q    <= lo_n;
      hi_q    <= hi_n;
      step_q  <= step_n;
      mode_q  <= mode_n;
      done    <= done_n;
      wrapped <= wrapped_n;
      cfg_err <= cfg_err_n;
    end
  end

  // Priority: start (restart or reject) > stop > accepted advance.
  always_comb begin
    state_n   = state_q;
    addr_n    = addr_q;
    dir_n     = dir_q;
    lo_n      = lo_q;
    hi_n      = hi_q;
    step_n    = step_q;
    mode_n    = mode_q;
    done_n    = 1'b0;
    wrapped_n = 1'b0;
    cfg_err_n = 1'b0;
    if (start) begin
      if (start_addr <= end_addr) begin
        state_n = S_RUN;
        lo_n    = start_addr;
        hi_n    = end_addr;
        step_n  = (step == '0) ? STEP_WIDTH'(1) : step;
        mode_n  = mode;
        dir_n   = forward;
        addr_n  = forward ? start_addr : end_addr;
      end else begin
        cfg_err_n = 1'b1;
      end
    end else if (stop) begin
      state_n = S_IDLE;
    end else if (state_q == S_RUN && addr_bus.addr_ready) begin
      addr_n = calc_addr;
      dir_n  = calc_dir;
      if (calc_boundary) begin
        if (mode_q == MODE_ONESHOT) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end else begin
          wrapped_n = 1'b1;
        end
      end
    end
  end

  assign addr_bus.address    = addr_q;
  assign addr_bus.addr_valid = (state_q == S_RUN);
  assign busy                = (state_q == S_RUN);
  assign dir                 = dir_q;
  assign state_dbg           = state_q;
endmodule

// File: tb/tb_address_sequencer.sv
// Directed bench for address_sequencer: a 32-bit instance for the main scenarios
// and an 8-bit instance for the top-of-address-space case.
module tb_address_sequencer;
  import addr_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] start_addr = '0;
  logic [31:0] end_addr = '0;
  logic [7:0]  step = 8'd1;
  logic [1:0]  mode = 2'd1;
  logic        forward = 1'b1;
  logic        ready = 1'b0;

  logic busy, dir, done, wrapped, cfg_err;
  logic busy8, dir8, done8, wrapped8, cfg_err8;
  state_t st, st8;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  address_sequencer_if #(.WIDTH(32)) bus32 ();
  address_sequencer_if #(.WIDTH(8))  bus8 ();
  assign bus32.addr_ready = ready;
  assign bus8.addr_ready  = ready;

  address_sequencer #(.WIDTH(32), .STEP_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .start_addr(start_addr), .end_addr(end_addr), .step(step), .mode(mode),
    .forward(forward), .addr_bus(bus32.master), .busy(busy), .dir(dir),
    .done(done), .wrapped(wrapped), .cfg_err(cfg_err), .state_dbg(st)
  );

  address_sequencer #(.WIDTH(8), .STEP_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .start_addr(start_addr[7:0]), .end_addr(end_addr[7:0]), .step(step), .mode(mode),
    .forward(forward), .addr_bus(bus8.master), .busy(busy8), .dir(dir8),
    .done(done8), .wrapped(wrapped8), .cfg_err(cfg_err8), .state_dbg(st8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one cycle, then scramble config to show it is ignored afterwards.
  task automatic launch(input logic [31:0] s, input logic [31:0] e, input logic [7:0] stp,
                        input logic [1:0] m, input logic f);
    start_addr = s; end_addr = e; step = stp; mode = m; forward = f; start = 1'b1;
    tick();
    start = 1'b0;
    start_addr = $urandom; end_addr = $urandom;
    step = 8'($urandom_range(0, 255)); mode = 2'($urandom_range(0, 3));
    forward = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    total++; if (bus32.address !== 32'd0) begin bad++; $display("FAIL reset_addr: got %0d want 0", bus32.address); end
    total++; if (busy !== 1'b0 || bus32.addr_valid !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b/%b want 0/0", busy, bus32.addr_valid); end
    total++; if (dir !== 1'b1) begin bad++; $display("FAIL reset_dir: got %b want 1", dir); end
    total++; if ({done, wrapped, cfg_err} !== 3'b000) begin bad++; $display("FAIL reset_pulses: got %b want 000", {done, wrapped, cfg_err}); end
    total++; if (st !== S_IDLE) begin bad++; $display("FAIL reset_state: got %0d want %0d", st, S_IDLE); end
    rst = 1'b0;
  endtask

  task automatic test_loop_up();
    int ea[5] = '{4, 7, 10, 4, 7};
    logic ew[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    ready = 1'b1;
    launch(32'd4, 32'd10, 8'd3, 2'd1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      total++; if (bus32.address !== ea[i]) begin bad++; $display("FAIL loop_up_addr[%0d]: got %0d want %0d", i, bus32.address, ea[i]); end
      total++; if (wrapped !== ew[i]) begin bad++; $display("FAIL loop_up_wrapped[%0d]: got %b want %b", i, wrapped, ew[i]); end
      if (i < 4) tick();
    end
  endtask

  task automatic test_loop_down();
    int ea[7] = '{5, 4, 3, 2, 1, 0, 5};
    ready = 1'b1;
    launch(32'd0, 32'd5, 8'd1, 2'd1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      total++; if (bus32.address !== ea[i]) begin bad++; $display("FAIL loop_down_addr[%0d]: got %0d want %0d", i, bus32.address, ea[i]); end
      total++; if (wrapped !== (i == 6) || dir !== 1'b0) begin bad++; $display("FAIL loop_down_flags[%0d]: got w=%b d=%b want w=%b d=0", i, wrapped, dir, (i == 6)); end
      if (i < 6) tick();
    end
  endtask

  task automatic test_pingpong();
    int ea[6] = '{4, 7, 10, 7, 4, 7};
    logic ed[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic ew[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    ready = 1'b1;
    launch(32'd4, 32'd10, 8'd3, 2'd2, 1'b1);
    for (int i = 0; i < 6; i++) begin
      total++; if (bus32.address !== ea[i]) begin bad++; $display("FAIL pp_addr[%0d]: got %0d want %0d", i, bus32.address, ea[i]); end
      total++; if (dir !== ed[i] || wrapped !== ew[i]) begin bad++; $display("FAIL pp_flags[%0d]: got d=%b w=%b want d=%b w=%b", i, dir, wrapped, ed[i], ew[i]); end
      if (i < 5) tick();
    end
  endtask

  task automatic test_oneshot();
    ready = 1'b1;
    launch(32'd0, 32'd3, 8'd1, 2'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      total++; if (bus32.address !== i || busy !== 1'b1) begin bad++; $display("FAIL os_addr[%0d]: got %0d busy=%b want %0d busy=1", i, bus32.address, busy, i); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL os_early_done[%0d]: got %b want 0", i, done); end
      tick();
    end
    total++; if (done !== 1'b1 || busy !== 1'b0 || bus32.address !== 32'd3) begin bad++; $display("FAIL os_end: got done=%b busy=%b addr=%0d want 1/0/3", done, busy, bus32.address); end
    tick();
    total++; if (done !== 1'b0 || bus32.address !== 32'd3) begin bad++; $display("FAIL os_after: got done=%b addr=%0d want 0/3", done, bus32.address); end
    // Handshake stalls: address must hold until accepted.
    ready = 1'b0;
    launch(32'd0, 32'd3, 8'd1, 2'd0, 1'b1);
    tick();
    total++; if (bus32.address !== 32'd0 || bus32.addr_valid !== 1'b1) begin bad++; $display("FAIL os_hold0: got %0d v=%b want 0 v=1", bus32.address, bus32.addr_valid); end
    ready = 1'b1; tick();
    total++; if (bus32.address !== 32'd1) begin bad++; $display("FAIL os_acc1: got %0d want 1", bus32.address); end
    ready = 1'b0; tick(); tick();
    total++; if (bus32.address !== 32'd1) begin bad++; $display("FAIL os_hold1: got %0d want 1", bus32.address); end
    ready = 1'b1; tick();
    total++; if (bus32.address !== 32'd2) begin bad++; $display("FAIL os_acc2: got %0d want 2", bus32.address); end
  endtask

  task automatic test_top_of_space();
    int ea[3] = '{250, 254, 250};
    ready = 1'b1;
    launch(32'd250, 32'd255, 8'd4, 2'd1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      total++; if (bus8.address !== 8'(ea[i])) begin bad++; $display("FAIL w8_addr[%0d]: got %0d want %0d", i, bus8.address, ea[i]); end
      total++; if (wrapped8 !== (i == 2)) begin bad++; $display("FAIL w8_wrapped[%0d]: got %b want %b", i, wrapped8, (i == 2)); end
      if (i < 2) tick();
    end
  endtask

  task automatic test_stop_rst_cfg();
    ready = 1'b1;
    launch(32'd0, 32'd5, 8'd1, 2'd1, 1'b1);
    tick();
    stop = 1'b1; tick(); stop = 1'b0;
    total++; if (busy !== 1'b0 || bus32.address !== 32'd1 || done !== 1'b0) begin bad++; $display("FAIL stop: got busy=%b addr=%0d done=%b want 0/1/0", busy, bus32.address, done); end
    tick();
    total++; if (bus32.address !== 32'd1 || busy !== 1'b0) begin bad++; $display("FAIL stop_idle: got addr=%0d busy=%b want 1/0", bus32.address, busy); end
    launch(32'd8, 32'd20, 8'd2, 2'd1, 1'b1);
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    total++; if (bus32.address !== 32'd0 || busy !== 1'b0 || dir !== 1'b1) begin bad++; $display("FAIL rst_mid: got addr=%0d busy=%b dir=%b want 0/0/1", bus32.address, busy, dir); end
    launch(32'd9, 32'd3, 8'd1, 2'd1, 1'b1);
    total++; if (cfg_err !== 1'b1 || busy !== 1'b0 || bus32.address !== 32'd0) begin bad++; $display("FAIL cfg_err: got err=%b busy=%b addr=%0d want 1/0/0", cfg_err, busy, bus32.address); end
    tick();
    total++; if (cfg_err !== 1'b0 || st !== S_IDLE) begin bad++; $display("FAIL cfg_err_pulse: got err=%b st=%0d want 0/IDLE", cfg_err, st); end
  endtask

  task automatic test_back_to_back();
    ready = 1'b1;
    launch(32'd4, 32'd10, 8'd3, 2'd1, 1'b1);
    tick();
    launch(32'd20, 32'd30, 8'd0, 2'd1, 1'b1);
    total++; if (bus32.address !== 32'd20) begin bad++; $display("FAIL restart: got %0d want 20", bus32.address); end
    tick();
    total++; if (bus32.address !== 32'd21) begin bad++; $display("FAIL step0: got %0d want 21", bus32.address); end
    launch(32'd6, 32'd6, 8'd5, 2'd3, 1'b1);
    tick();
    total++; if (bus32.address !== 32'd6 || wrapped !== 1'b1) begin bad++; $display("FAIL eq_bounds1: got addr=%0d w=%b want 6/1", bus32.address, wrapped); end
    tick();
    total++; if (bus32.address !== 32'd6 || wrapped !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL eq_bounds2: got addr=%0d w=%b b=%b want 6/1/1", bus32.address, wrapped, busy); end
    launch(32'd6, 32'd6, 8'd5, 2'd0, 1'b0);
    tick();
    total++; if (done !== 1'b1 || busy !== 1'b0 || bus32.address !== 32'd6) begin bad++; $display("FAIL eq_oneshot: got done=%b busy=%b addr=%0d want 1/0/6", done, busy, bus32.address); end
  endtask

  initial begin
    test_reset();
    test_loop_up();
    test_loop_down();
    test_pingpong();
    test_oneshot();
    test_top_of_space();
    test_stop_rst_cfg();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
